// File: rtl/i2c_xfer_pkg.sv
// Shared encodings for the I2C byte sequencer.
// Command opcodes, FSM states and bit-phase numbering.
package i2c_xfer_pkg;

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;
  localparam logic [1:0] CMD_STOP  = 2'd3;

  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;
  localparam logic [1:0] P3 = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_START,
    S_BIT,
    S_ACK,
    S_STOP
  } state_t;

endpackage

// File: rtl/i2c_xfer_tick.sv
// Quarter-bit prescaler and phase counter.
// Holds its count while a stretching slave keeps SCL low.
module i2c_xfer_tick
  import i2c_xfer_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             hold,
  input  logic [DIV_W-1:0] clkdiv,
  output logic             phaseEnd,
  output logic [1:0]       phase
);

  logic [DIV_W-1:0] cnt;

  assign phaseEnd = run && !hold && (cnt == '0);

  // divisor is only sampled at a phase start
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      phase <= P0;
    end else if (!run) begin
      cnt   <= clkdiv;
      phase <= P0;
    end else if (phaseEnd) begin
      cnt   <= clkdiv;
      phase <= phase + 2'd1;
    end else if (!hold) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/i2c_xfer_ctrl.sv
// Byte-level I2C master sequencer.
// Turns START/WRITE/READ/STOP commands into SCL/SDA pulls.
module i2c_xfer_ctrl
  import i2c_xfer_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] clkdiv,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [7:0]       cmd_data,
  input  logic             cmd_ack,
  output logic             rd_valid,
  output logic [7:0]       rd_data,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             scl_oe,
  output logic             sda_oe,
  output logic             setDone,
  output logic             setNoAck,
  output logic             setArbFail,
  output logic             active
);

  state_t     state;
  state_t     stateNxt;
  logic [1:0] opReg;
  logic       ackReg;
  logic [7:0] shift;
  logic [2:0] bitCnt;
  logic       sampleBit;
  logic       accept;
  logic       run;
  logic       hold;
  logic       phaseEnd;
  logic [1:0] phase;
  logic       isWrite;
  logic       lowPhase;
  logic       sclOe;
  logic       sdaOe;
  logic       done;
  logic       noAck;
  logic       arbFail;
  logic       rdValid;

  assign accept = !rst && enable && cmd_valid
                  && (state == S_IDLE || state == S_HOLD);
  assign run = (state == S_START) || (state == S_BIT)
               || (state == S_ACK) || (state == S_STOP);
  assign hold = !sclOe && !scl_i;
  assign isWrite = (opReg == CMD_WRITE);
  assign lowPhase = (phase == P0) || (phase == P3);

  i2c_xfer_tick #(
    .DIV_W(DIV_W)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .hold    (hold),
    .clkdiv  (clkdiv),
    .phaseEnd(phaseEnd),
    .phase   (phase)
  );

  always_comb begin
    stateNxt = state;
    sclOe    = 1'b0;
    sdaOe    = 1'b0;
    done     = 1'b0;
    noAck    = 1'b0;
    arbFail  = 1'b0;
    rdValid  = 1'b0;
    unique case (state)
      S_IDLE: begin
        // data/stop with no bus owned are simply swallowed
        if (accept && cmd_op == CMD_START) stateNxt = S_START;
      end
      S_HOLD: begin
        sclOe = 1'b1;
        if (accept) begin
          unique case (cmd_op)
            CMD_START: stateNxt = S_START;
            CMD_STOP:  stateNxt = S_STOP;
            default:   stateNxt = S_BIT;
          endcase
        end
      end
      S_START: begin
        sclOe = lowPhase;
        sdaOe = (phase == P2) || (phase == P3);
        if (phaseEnd && phase == P1 && !sda_i) begin
          arbFail  = 1'b1;
          stateNxt = S_IDLE;
        end else if (phaseEnd && phase == P3) begin
          done     = 1'b1;
          stateNxt = S_HOLD;
        end
      end
      S_BIT: begin
        sclOe = lowPhase;
        sdaOe = isWrite && !shift[7];
        if (phaseEnd && phase == P2 && isWrite
            && shift[7] && !sda_i) begin
          arbFail  = 1'b1;
          stateNxt = S_IDLE;
        end else if (phaseEnd && phase == P3
                     && bitCnt == 3'd7) begin
          stateNxt = S_ACK;
        end
      end
      S_ACK: begin
        sclOe = lowPhase;
        sdaOe = !isWrite && !ackReg;
        if (phaseEnd && phase == P3) begin
          done     = 1'b1;
          noAck    = isWrite && sampleBit;
          rdValid  = !isWrite;
          stateNxt = S_HOLD;
        end
      end
      S_STOP: begin
        sclOe = (phase == P0);
        sdaOe = (phase == P0) || (phase == P1);
        if (phaseEnd && phase == P3) begin
          done     = 1'b1;
          stateNxt = S_IDLE;
        end
      end
      default: stateNxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      opReg     <= CMD_START;
      ackReg    <= 1'b0;
      shift     <= 8'h00;
      bitCnt    <= 3'd0;
      sampleBit <= 1'b0;
      rd_data   <= 8'h00;
    end else begin
      state <= stateNxt;
      if (accept) begin
        opReg  <= cmd_op;
        ackReg <= cmd_ack;
        shift  <= cmd_data;
        bitCnt <= 3'd0;
      end else if (phaseEnd) begin
        if (phase == P2) sampleBit <= sda_i;
        // shifting after SCL falls keeps SDA stable while high
        if (phase == P3 && state == S_BIT) begin
          shift  <= {shift[6:0], sampleBit};
          bitCnt <= bitCnt + 3'd1;
          if (bitCnt == 3'd7 && !isWrite)
            rd_data <= {shift[6:0], sampleBit};
        end
      end
    end
  end

  assign cmd_ready  = accept;
  assign scl_oe     = sclOe;
  assign sda_oe     = sdaOe;
  assign setDone    = done && !rst;
  assign setNoAck   = noAck && !rst;
  assign setArbFail = arbFail && !rst;
  assign rd_valid   = rdValid && !rst;
  assign active     = (state != S_IDLE);

endmodule

// File: tb/tb_i2c_xfer_ctrl.sv
// Directed bench for the I2C byte sequencer.
// A small slave model answers on the bus; expected values are hand-computed.
module tb_i2c_xfer_ctrl;

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_STOP  = 2'd3;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] clkdiv;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic        cmd_ack;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        scl_i;
  logic        sda_i;
  logic        scl_oe;
  logic        sda_oe;
  logic        setDone;
  logic        setNoAck;
  logic        setArbFail;
  logic        active;

  int checks = 0;
  int failures = 0;

  // slave model configuration
  logic       slvRead = 1'b0;
  logic [7:0] slvByte = 8'h00;
  logic       slvAck = 1'b0;
  int         arbBit = -1;
  int         stretchBit = -1;
  logic       slvSda = 1'b1;
  logic       stretch = 1'b0;
  int         stretchLeft = 0;

  // monitor state
  int       cyc = 0;
  logic     prevScl = 1'b0;
  logic [3:0] prevPl = 4'b0;
  int       relCount = 0;
  int       fallCount = 0;
  int       relTime [0:11];
  logic     sdaAtRel [0:11];
  int       doneCnt = 0;
  int       doneCyc = -1;
  int       noAckCnt = 0;
  int       noAckCyc = -1;
  int       arbCnt = 0;
  int       arbCyc = -1;
  int       rdvCnt = 0;
  int       rdvCyc = -1;
  logic [7:0] rdSeen = 8'h00;
  logic     anyDrive = 1'b0;
  int       accCyc = 0;
  int       widthErr = 0;
  int       overlapErr = 0;

  assign scl_i = ~scl_oe & ~stretch;
  assign sda_i = ~sda_oe & slvSda;

  i2c_xfer_ctrl #(.DIV_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .clkdiv    (clkdiv),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_ack   (cmd_ack),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_oe    (scl_oe),
    .sda_oe    (sda_oe),
    .setDone   (setDone),
    .setNoAck  (setNoAck),
    .setArbFail(setArbFail),
    .active    (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    logic [3:0] pl;
    @(negedge clk);
    cyc++;
    if (!scl_oe && prevScl) begin
      if (relCount < 12) begin
        relTime[relCount] = cyc;
        sdaAtRel[relCount] = ~sda_oe;
      end
      if (relCount == stretchBit) stretchLeft = 20;
      relCount++;
    end
    if (scl_oe && !prevScl) fallCount++;
    prevScl = scl_oe;
    slvSda = 1'b1;
    if (slvRead && fallCount < 8) slvSda = slvByte[7 - fallCount];
    if (!slvRead && fallCount == 8) slvSda = slvAck;
    if (arbBit >= 0 && fallCount == arbBit && relCount == arbBit + 1)
      slvSda = 1'b0;
    stretch = (stretchLeft > 0);
    if (stretchLeft > 0) stretchLeft--;
    #1;
    pl = {setDone, setNoAck, setArbFail, rd_valid};
    if ((pl & prevPl) != 4'b0) widthErr++;
    prevPl = pl;
    if (setNoAck && setArbFail) overlapErr++;
    if (scl_oe || sda_oe) anyDrive = 1'b1;
    if (setDone) begin doneCnt++; doneCyc = cyc; end
    if (setNoAck) begin noAckCnt++; noAckCyc = cyc; end
    if (setArbFail) begin arbCnt++; arbCyc = cyc; end
    if (rd_valid) begin rdvCnt++; rdvCyc = cyc; rdSeen = rd_data; end
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] d,
                       input logic a);
    logic seen;
    relCount = 0; fallCount = 0;
    doneCnt = 0; noAckCnt = 0; arbCnt = 0; rdvCnt = 0;
    doneCyc = -1; noAckCyc = -1; arbCyc = -1; rdvCyc = -1;
    anyDrive = 1'b0;
    cmd_op = op; cmd_data = d; cmd_ack = a; cmd_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      #1;
      if (cmd_ready) seen = 1'b1;
      else step();
    end
    accCyc = cyc;
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL issue_timeout op=%0d ready=%0b required=1", op, cmd_ready);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int maxCyc);
    int n;
    n = 0;
    while (doneCnt == 0 && arbCnt == 0 && n < maxCyc) begin
      step();
      n++;
    end
    checks++;
    if (n >= maxCyc) begin
      failures++;
      $display("FAIL done_timeout cycles=%0d limit=%0d", n, maxCyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; clkdiv = 16'd1;
    cmd_valid = 1'b1; cmd_op = OP_START; cmd_data = 8'h00; cmd_ack = 1'b0;
    step();
    step();
    checks++;
    if ({scl_oe, sda_oe, active, setDone, setNoAck, setArbFail,
         rd_valid, cmd_ready} !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs got=%b required=00000000",
               {scl_oe, sda_oe, active, setDone, setNoAck,
                setArbFail, rd_valid, cmd_ready});
    end
    checks++;
    if (rd_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_rd_data got=%h required=00", rd_data);
    end
    cmd_valid = 1'b0;
    rst = 1'b0;
    step();
    checks++;
    if (active !== 1'b0 || scl_oe !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle active=%b scl_oe=%b required=0 0", active, scl_oe);
    end
  endtask

  task automatic test_idle_consume();
    issue(OP_WRITE, 8'h55, 1'b0);
    issue(OP_STOP, 8'h00, 1'b0);
    repeat (20) step();
    checks++;
    if (anyDrive !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_bus got=%b required=0", anyDrive);
    end
    checks++;
    if (doneCnt + noAckCnt + arbCnt + rdvCnt != 0) begin
      failures++;
      $display("FAIL idle_no_pulses got=%0d required=0", doneCnt + noAckCnt + arbCnt + rdvCnt);
    end
    checks++;
    if (active !== 1'b0) begin
      failures++;
      $display("FAIL idle_active got=%b required=0", active);
    end
  endtask

  task automatic test_start();
    clkdiv = 16'd0;
    issue(OP_START, 8'h00, 1'b0);
    wait_done(40);
    checks++;
    if (doneCyc != accCyc + 4) begin
      failures++;
      $display("FAIL start_div0_len got=%0d required=%0d", doneCyc - accCyc, 4);
    end
    checks++;
    if (relCount != 1 || relTime[0] != accCyc + 2 || sdaAtRel[0] !== 1'b1) begin
      failures++;
      $display("FAIL start_div0_rise rel=%0d at=%0d sda=%b required=1 %0d 1", relCount, relTime[0] - accCyc, sdaAtRel[0], 2);
    end
    step();
    checks++;
    if (active !== 1'b1 || scl_oe !== 1'b1) begin
      failures++;
      $display("FAIL start_hold active=%b scl_oe=%b required=1 1", active, scl_oe);
    end
    clkdiv = 16'd1;
    issue(OP_START, 8'h00, 1'b0);
    wait_done(80);
    checks++;
    if (doneCyc != accCyc + 8 || arbCnt != 0) begin
      failures++;
      $display("FAIL restart_div1_len got=%0d arb=%0d required=8 0", doneCyc - accCyc, arbCnt);
    end
    checks++;
    if (relTime[0] != accCyc + 3) begin
      failures++;
      $display("FAIL restart_rise got=%0d required=3", relTime[0] - accCyc);
    end
    step();
  endtask

  task automatic test_write_ack();
    logic [7:0] got;
    slvRead = 1'b0; slvAck = 1'b0;
    issue(OP_WRITE, 8'hA5, 1'b0);
    wait_done(200);
    got = 8'h00;
    for (int i = 0; i < 8; i++) got = {got[6:0], sdaAtRel[i]};
    checks++;
    if (got !== 8'hA5) begin
      failures++;
      $display("FAIL write_bits got=%h required=a5", got);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (relTime[i+1] - relTime[i] != 8) begin
        failures++;
        $display("FAIL write_bit_len bit=%0d got=%0d required=8", i, relTime[i+1] - relTime[i]);
      end
    end
    checks++;
    if (relCount != 9 || doneCyc != relTime[8] + 5) begin
      failures++;
      $display("FAIL write_done_time rel=%0d got=%0d required=9 5", relCount, doneCyc - relTime[8]);
    end
    step();
    checks++;
    if (noAckCnt != 0 || active !== 1'b1 || doneCnt != 1) begin
      failures++;
      $display("FAIL write_ack_state noack=%0d active=%b done=%0d required=0 1 1", noAckCnt, active, doneCnt);
    end
  endtask

  task automatic test_write_noack();
    slvAck = 1'b1;
    issue(OP_WRITE, 8'h3C, 1'b0);
    wait_done(200);
    step();
    step();
    checks++;
    if (noAckCnt != 1 || doneCnt != 1 || noAckCyc != doneCyc) begin
      failures++;
      $display("FAIL noack_pulse noack=%0d done=%0d dcyc=%0d ncyc=%0d required=1 1 equal", noAckCnt, doneCnt, doneCyc, noAckCyc);
    end
    checks++;
    if (active !== 1'b1 || scl_oe !== 1'b1) begin
      failures++;
      $display("FAIL noack_hold active=%b scl_oe=%b required=1 1", active, scl_oe);
    end
    slvAck = 1'b0;
  endtask

  task automatic test_stretch();
    stretchBit = 4;
    issue(OP_WRITE, 8'h5A, 1'b0);
    wait_done(300);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (relTime[i+1] - relTime[i] != (i == 4 ? 28 : 8)) begin
        failures++;
        $display("FAIL stretch_bit_len bit=%0d got=%0d required=%0d", i, relTime[i+1] - relTime[i], (i == 4 ? 28 : 8));
      end
    end
    stretchBit = -1;
    step();
  endtask

  task automatic test_read();
    slvRead = 1'b1; slvByte = 8'h3C;
    issue(OP_READ, 8'h00, 1'b1);
    wait_done(200);
    checks++;
    if (rdvCnt != 1 || rdSeen !== 8'h3C || rdvCyc != doneCyc) begin
      failures++;
      $display("FAIL read_nack_data cnt=%0d data=%h vcyc=%0d dcyc=%0d required=1 3c equal", rdvCnt, rdSeen, rdvCyc, doneCyc);
    end
    checks++;
    if (sdaAtRel[8] !== 1'b1) begin
      failures++;
      $display("FAIL read_nack_sda got=%b required=1", sdaAtRel[8]);
    end
    step();
    checks++;
    if (rd_data !== 8'h3C) begin
      failures++;
      $display("FAIL read_hold_data got=%h required=3c", rd_data);
    end
    slvByte = 8'h81;
    issue(OP_READ, 8'h00, 1'b0);
    wait_done(200);
    checks++;
    if (rdSeen !== 8'h81 || sdaAtRel[8] !== 1'b0) begin
      failures++;
      $display("FAIL read_ack data=%h sda=%b required=81 0", rdSeen, sdaAtRel[8]);
    end
    slvRead = 1'b0;
    step();
  endtask

  task automatic test_stop();
    issue(OP_STOP, 8'h00, 1'b0);
    enable = 1'b0;
    wait_done(80);
    checks++;
    if (sdaAtRel[0] !== 1'b0 || doneCyc != relTime[0] + 5) begin
      failures++;
      $display("FAIL stop_seq sda=%b len=%0d required=0 5", sdaAtRel[0], doneCyc - relTime[0]);
    end
    step();
    checks++;
    if (active !== 1'b0 || scl_oe !== 1'b0 || sda_oe !== 1'b0) begin
      failures++;
      $display("FAIL stop_idle active=%b scl=%b sda=%b required=0 0 0", active, scl_oe, sda_oe);
    end
    enable = 1'b1;
  endtask

  task automatic test_arb();
    issue(OP_START, 8'h00, 1'b0);
    wait_done(80);
    step();
    arbBit = 2;
    issue(OP_WRITE, 8'hFF, 1'b0);
    wait_done(200);
    checks++;
    if (arbCnt != 1 || arbCyc != relTime[2] + 3) begin
      failures++;
      $display("FAIL arb_pulse cnt=%0d at=%0d required=1 3", arbCnt, arbCyc - relTime[2]);
    end
    step();
    checks++;
    if (scl_oe !== 1'b0 || sda_oe !== 1'b0 || active !== 1'b0) begin
      failures++;
      $display("FAIL arb_release scl=%b sda=%b active=%b required=0 0 0", scl_oe, sda_oe, active);
    end
    arbBit = -1;
    repeat (20) step();
    checks++;
    if (doneCnt != 0 || arbCnt != 1) begin
      failures++;
      $display("FAIL arb_no_done done=%0d arb=%0d required=0 1", doneCnt, arbCnt);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int hits;
    issue(OP_START, 8'h00, 1'b0);
    wait_done(80);
    step();
    issue(OP_WRITE, 8'h96, 1'b0);
    n = 0;
    while (relCount < 6 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (relCount < 6 || scl_oe !== 1'b0) begin
      failures++;
      $display("FAIL mid_reach_bit5 rel=%0d scl=%b required=6 0", relCount, scl_oe);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({setDone, setNoAck, setArbFail, rd_valid, cmd_ready} !== 5'b0) begin
      failures++;
      $display("FAIL mid_reset_pulses got=%b required=00000", {setDone, setNoAck, setArbFail, rd_valid, cmd_ready});
    end
    step();
    checks++;
    if (scl_oe !== 1'b0 || sda_oe !== 1'b0 || active !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_release scl=%b sda=%b active=%b required=0 0 0", scl_oe, sda_oe, active);
    end
    rst = 1'b0;
    enable = 1'b0;
    cmd_op = OP_START;
    cmd_valid = 1'b1;
    hits = 0;
    repeat (3) begin
      step();
      if (cmd_ready) hits++;
    end
    checks++;
    if (hits != 0 || doneCnt != 0) begin
      failures++;
      $display("FAIL mid_ready_disabled hits=%0d done=%0d required=0 0", hits, doneCnt);
    end
    enable = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_ready_enabled got=%b required=1", cmd_ready);
    end
    cmd_valid = 1'b0;
    step();
  endtask

  task automatic test_pulse_rules();
    checks++;
    if (widthErr != 0) begin
      failures++;
      $display("FAIL pulse_width got=%0d required=0", widthErr);
    end
    checks++;
    if (overlapErr != 0) begin
      failures++;
      $display("FAIL noack_arb_overlap got=%0d required=0", overlapErr);
    end
  endtask

  initial begin
    test_reset();
    test_idle_consume();
    test_start();
    test_write_ack();
    test_write_noack();
    test_stretch();
    test_read();
    test_stop();
    test_arb();
    test_reset_mid();
    test_pulse_rules();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_xfer_ctrl.md
Name: i2c_xfer_ctrl

Overview:
- Byte-level I2C master sequencer. Accepts START/WRITE/READ/STOP commands from the register/FIFO front end and drives the open-drain SCL/SDA enables with a programmable quarter-bit timebase.
- Produces the setDone/setNoAck/setArbFail pulses and the active level consumed by i2c_status.
- Sits between the TX/RX FIFOs and the pad cells.

Parameters:
- DIV_W, 16, width of the quarter-period prescaler input clkdiv

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  core enable; when low, no new command is accepted
- clkdiv  in  DIV_W  quarter-bit period minus 1, in clk cycles
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this cycle (valid&ready)
- cmd_op  in  2  0=START, 1=WRITE, 2=READ, 3=STOP
- cmd_data  in  8  byte for WRITE
- cmd_ack  in  1  READ: 0=master drives ACK, 1=master sends NACK
- rd_valid  out  1  one-cycle pulse, rd_data valid
- rd_data  out  8  received byte, MSB first
- scl_i  in  1  SCL pad input (pre-synchronised)
- sda_i  in  1  SDA pad input (pre-synchronised)
- scl_oe  out  1  1=pull SCL low
- sda_oe  out  1  1=pull SDA low
- setDone  out  1  one-cycle pulse, command complete
- setNoAck  out  1  one-cycle pulse, WRITE byte not acknowledged
- setArbFail  out  1  one-cycle pulse, arbitration lost
- active  out  1  bus owned by this master

Behaviour:
- Reset values:
  - all outputs 0; scl_oe=sda_oe=0 (lines released); rd_data=0.
  - state=IDLE; prescaler=0.
  - Reset mid-operation releases both lines on the next edge and emits no pulses.
- Timebase:
  - Each bit is four phases P0..P3; each phase lasts clkdiv+1 clk cycles.
  - clkdiv=0 gives 4 clk per bit.
  - The prescaler reloads at each phase start.
- Clock stretching: in any phase where scl_oe=0 following a low phase, the prescaler holds until scl_i=1.
- cmd_ready:
  - Asserted for exactly one cycle, only in IDLE/HOLD with enable=1.
  - The command is registered on acceptance.
- States: IDLE, HOLD (active, SCL held low between commands), START, BIT, ACK, STOP.
- START (allowed from IDLE, or HOLD for a repeated start):
  - P0: SDA released, SCL low.
  - P1: SCL released, with stretch wait.
  - P2: SDA low.
  - P3: SCL low.
  - active goes to 1 on acceptance.
  - If sda_i=0 at the end of P1: setArbFail, release both lines, go to IDLE, active=0.
  - On completion: setDone, then HOLD.
- BIT, 8 bits MSB first:
  - P0: SCL low, SDA set (WRITE: data bit; READ: released).
  - P1: SCL released, with stretch.
  - P2: SCL high; sample sda_i at the last cycle of P2.
  - P3: SCL low.
- ACK bit: same phase timing.
  - WRITE: SDA released; sampled 1 gives setNoAck.
  - READ: SDA driven to cmd_ack inverted-sense (sda_oe=~cmd_ack); rd_data is updated and rd_valid pulses at the end of P3.
  - setDone pulses at the end of the ACK bit, in the same cycle as setNoAck/rd_valid. Next state is HOLD.
- Arbitration (WRITE data bits only): SDA released (bit=1) and sampled 0 gives:
  - setArbFail in the sample cycle;
  - scl_oe=sda_oe=0 next cycle;
  - IDLE, active=0;
  - no setDone for that byte.
- STOP:
  - P0: SCL low, SDA low.
  - P1: SCL released, with stretch.
  - P2: SDA released.
  - P3: idle.
  - Then setDone, active=0, IDLE.
- WRITE/READ/STOP accepted in IDLE (not active): consumed in one cycle with no bus activity, no pulses, and state stays IDLE.
- enable deasserted mid-command: the current command completes; no further acceptance.
- clkdiv change mid-command takes effect at the next phase start.
- Pulse outputs are never asserted for more than one cycle. setNoAck and setArbFail are never asserted together.

Decomposition:
- Package i2c_xfer_pkg:
  - cmd_op encodings (CMD_START/WRITE/READ/STOP);
  - state encoding;
  - phase constants P0..P3.
- Sub-module i2c_xfer_tick: prescaler with stretch-hold. Inputs clk, rst, clkdiv, hold; outputs phase_end pulse and phase[1:0].
- The main FSM, shift register and bit counter stay in i2c_xfer_ctrl.

Test Plan:
- clkdiv=1, START then WRITE 0xA5, slave ACK (sda_i=0 in ACK):
  - SDA levels at SCL rise are 1,0,1,0,0,1,0,1;
  - 8 clk per bit;
  - setDone pulse at the end of bit 9; setNoAck=0; active=1.
- WRITE 0x3C with sda_i=1 during ACK: setNoAck and setDone in the same single cycle; state HOLD.
- START, WRITE 0xFF, force sda_i=0 during P2 of bit 2:
  - setArbFail one pulse;
  - scl_oe=sda_oe=0 next cycle;
  - active=0; no setDone.
- Slave holds scl_i low 20 extra cycles in bit 4 of a write (clkdiv=1): that bit lasts 28 clk; all other bits 8.
- READ with cmd_ack=1, slave returns 0x3C:
  - rd_data=0x3C with rd_valid pulse coincident with setDone;
  - sda_oe=0 during ACK.
- STOP, then assert rst for 1 cycle mid-WRITE bit 5:
  - STOP yields setDone and active=0;
  - the reset releases both lines next cycle, no pulses, cmd_ready=0 until IDLE with enable.
